rf_port_arbiter: RTL and testbench
==================================

Name: rf_port_arbiter

Overview:
- Shares the 4-entry, 512-bit register file between NUM_REQ requesters, e.g. ALU writeback, load unit and debug/host port.
- Round-robin arbitration, one command accepted per cycle, two-stage pipeline: ACCEPT, then ISSUE to the register file, then a registered response.
- Owns the register file's writeFlag/addr1/addr2/dataIn pins; no other block drives them.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- DATA_W, 512, register data width
- ADDR_W, 2, register address width (4 registers)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  one-hot accept strobe; handshake completes on valid&ready
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr1  in  NUM_REQ*ADDR_W  read port 1 address, or write address
- req_addr2  in  NUM_REQ*ADDR_W  read port 2 address (ignored on write)
- req_wdata  in  NUM_REQ*DATA_W  write data
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle completion pulse to the originating requester
- rsp_data1  out  DATA_W  read data port 1, or echoed write data
- rsp_data2  out  DATA_W  read data port 2 (0 on write)
- rf_write_flag  out  1  to register file writeFlag
- rf_addr1  out  ADDR_W  to register file addr1
- rf_addr2  out  ADDR_W  to register file addr2
- rf_data_in  out  DATA_W  to register file dataIn
- rf_data_out1  in  DATA_W  from register file dataOut1 (combinational read)
- rf_data_out2  in  DATA_W  from register file dataOut2

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data1/2=0, rf_write_flag=0, rf_addr1/2=0, rf_data_in=0, issue-stage valid=0, RR pointer=0.
- ACCEPT (cycle t):
  - req_ready is combinational.
  - Winner = first requester with req_valid set, scanning from the pointer upward with wrap.
  - Exactly one req_ready bit is high when any req_valid is high; all are 0 otherwise.
  - On acceptance, the command {write, addr1, addr2, wdata, id} is registered into the issue stage, and pointer = (winner+1) mod NUM_REQ.
  - Pointer is unchanged when nothing is accepted.
- ISSUE (cycle t+1):
  - rf_addr1/rf_addr2/rf_data_in are driven from the issue register.
  - rf_write_flag = issue_valid & write. The write commits at the end of t+1.
  - For a read, rf_data_out1/2 are sampled at the end of t+1.
  - No backpressure: a new command may be accepted in the same cycle, so throughput is 1 command per cycle.
- RESPONSE (cycle t+2):
  - rsp_valid[id]=1 for exactly one cycle.
  - rsp_data1/2 are held until the next response.
  - A write response returns rsp_data1=wdata and rsp_data2=0.
- Latency: 2 cycles from accept to rsp_valid, for reads and writes alike.
- Ordering:
  - Commands complete in acceptance order.
  - A read accepted the cycle after a write to the same address returns the new value, because the write committed before the read's ISSUE cycle. No forwarding is needed.
- Address aliasing: a read with addr1==addr2 returns the same value on both data ports.
- Idle ISSUE cycle: rf_write_flag=0; rf_addr/data hold their last values.
- Reset mid-operation:
  - In-flight commands are discarded with no rsp_valid.
  - rf_write_flag drops to 0 asynchronously, so no partial write occurs.
  - Pointer returns to 0.
- Requester dropping req_valid before ready: legal; nothing is accepted and the pointer is unchanged.

Optional Feature:
- RF_ARB_LOCK_EN defined:
  - Adds input req_lock[NUM_REQ].
  - A granted command with lock=1 makes its requester the sole eligible winner on following cycles; the pointer is frozen.
  - The lock ends when that requester's accepted command has lock=0, or on reset.
  - While locked with the owner's req_valid=0, no grant is issued.
  - Used for atomic multi-register sequences.
- Undefined: no req_lock port; pure round-robin.

Decomposition:
- Package rf_arb_pkg:
  - Constants RF_DATA_W=512, RF_ADDR_W=2, RF_NUM_REGS=4.
  - Typedef rf_cmd_t {write, addr1, addr2, wdata, id}.
  - Typedef rf_rsp_t {id, data1, data2}.
- Sub-module rr_arbiter (NUM_REQ): combinational one-hot grant from req vector plus pointer, with the pointer register; lock hook under RF_ARB_LOCK_EN.

Test Plan:
- Reset, then requester 0 writes A2 (addr1=1) = 0x5A..5A; requester 0 reads addr1=1, addr2=1 back-to-back.
  - Expect rf_write_flag high for exactly 1 cycle.
  - Expect the write rsp_valid[0] at t+2.
  - Expect the read rsp at t+3 with data1=data2=0x5A..5A.
- All 3 requesters hold valid for 6 cycles.
  - Expect req_ready sequence 001,010,100,001,010,100.
  - Expect responses in the same order, 2 cycles later.
- Requester 1 writes A4=0x1234; in the next cycle requester 2 reads addr1=3, addr2=0.
  - Expect rsp_data1=0x1234 and rsp_data2=0 (A1 reset value).
- Assert reset in the ISSUE cycle of a write to A3=0xFF.
  - Expect no rsp_valid and rf_write_flag=0 immediately.
  - A later read of A3 returns 0.
- With RF_ARB_LOCK_EN: requester 2 issues lock=1 twice, then lock=0, while requesters 0 and 1 are also valid.
  - Expect three consecutive grants to requester 2, then a grant to requester 0.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file port arbiter.
// RF_ARB_LOCK_EN enables the lock state used by rr_arbiter.
package rf_arb_pkg;

    localparam int unsigned RF_DATA_W   = 512;
    localparam int unsigned RF_ADDR_W   = 2;
    localparam int unsigned RF_NUM_REGS = 4;
    localparam int unsigned RF_MAX_REQ  = 8;
    localparam int unsigned RF_ID_W     = 3;

    typedef struct packed {
        logic                 write;
        logic [RF_ADDR_W-1:0] addr1;
        logic [RF_ADDR_W-1:0] addr2;
        logic [RF_DATA_W-1:0] wdata;
        logic [RF_ID_W-1:0]   id;
    } rf_cmd_t;

    typedef struct packed {
        logic [RF_ID_W-1:0]   id;
        logic [RF_DATA_W-1:0] data1;
        logic [RF_DATA_W-1:0] data2;
    } rf_rsp_t;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Width of a requester index; never below one bit.
    function automatic int unsigned rf_ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_port_arbiter_if.sv
// Requester-side command/response bundle of the register-file arbiter.
// RF_ARB_LOCK_EN adds the per-requester req_lock signal.
interface rf_port_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = RF_DATA_W,
    parameter int unsigned ADDR_W  = RF_ADDR_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr1;
    logic [NUM_REQ*ADDR_W-1:0] req_addr2;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
`ifdef RF_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock;
`endif
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data1;
    logic [DATA_W-1:0]         rsp_data2;

    modport master (
`ifdef RF_ARB_LOCK_EN
        output req_lock,
`endif
        output req_valid, req_write, req_addr1, req_addr2, req_wdata,
        input  req_ready, rsp_valid, rsp_data1, rsp_data2
    );

    modport slave (
`ifdef RF_ARB_LOCK_EN
        input  req_lock,
`endif
        input  req_valid, req_write, req_addr1, req_addr2, req_wdata,
        output req_ready, rsp_valid, rsp_data1, rsp_data2
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant with its rotating pointer.
// RF_ARB_LOCK_EN lets a granted requester hold exclusive ownership.
module rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ = 3,
    localparam int unsigned PTR_W   = rf_ptr_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req,
`ifdef RF_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0] i_lock,
`endif
    output logic [NUM_REQ-1:0] o_grant_c,
    output logic [PTR_W-1:0]   o_grant_id_c
);

    localparam int unsigned SUM_W = PTR_W + 1;

    logic [PTR_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] w_elig;
    logic [SUM_W-1:0]   w_sum;
    logic [PTR_W-1:0]   w_idx;
    logic               w_found;
    logic [PTR_W-1:0]   w_ptr_nxt;

`ifdef RF_ARB_LOCK_EN
    arb_state_t         r_state;
    logic [PTR_W-1:0]   r_owner;

    // While locked only the owner may win.
    always_comb begin
        w_elig = i_req;
        if (r_state == ARB_LOCKED) begin
            w_elig          = '0;
            w_elig[r_owner] = i_req[r_owner];
        end
    end
`else
    assign w_elig = i_req;
`endif

    // Scan from the pointer upward with wrap; first eligible requester wins.
    always_comb begin
        o_grant_c    = '0;
        o_grant_id_c = '0;
        w_found      = 1'b0;
        w_sum        = '0;
        w_idx        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + SUM_W'(i);
            if (w_sum >= SUM_W'(NUM_REQ)) begin
                w_sum = w_sum - SUM_W'(NUM_REQ);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && w_elig[w_idx]) begin
                w_found          = 1'b1;
                o_grant_c[w_idx] = 1'b1;
                o_grant_id_c     = w_idx;
            end
        end
    end

    assign w_ptr_nxt = (o_grant_id_c == PTR_W'(NUM_REQ - 1)) ? '0 : o_grant_id_c + 1'b1;

`ifdef RF_ARB_LOCK_EN
    // Pointer freezes for the whole lock; the unlocking grant does not move it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_state <= ARB_FREE;
            r_owner <= '0;
        end else if (|o_grant_c) begin
            case (r_state)
                ARB_FREE: begin
                    r_ptr <= w_ptr_nxt;
                    if (i_lock[o_grant_id_c]) begin
                        r_state <= ARB_LOCKED;
                        r_owner <= o_grant_id_c;
                    end
                end
                ARB_LOCKED: begin
                    if (!i_lock[o_grant_id_c]) begin
                        r_state <= ARB_FREE;
                    end
                end
                default: r_state <= ARB_FREE;
            endcase
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (|o_grant_c) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares the register file between NUM_REQ requesters: accept, issue, respond.
// RF_ARB_LOCK_EN adds requester locking for atomic multi-register sequences.
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ = 3,
    parameter int unsigned  DATA_W  = RF_DATA_W,
    parameter int unsigned  ADDR_W  = RF_ADDR_W,
    localparam int unsigned PTR_W   = rf_ptr_w(NUM_REQ)
) (
    input  logic              clk,
    input  logic              reset,
    rf_port_arbiter_if.slave  bus,
    output logic              rf_write_flag,
    output logic [ADDR_W-1:0] rf_addr1,
    output logic [ADDR_W-1:0] rf_addr2,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out1,
    input  logic [DATA_W-1:0] rf_data_out2
);

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_grant_id;
    logic [ADDR_W-1:0]  w_addr1 [NUM_REQ];
    logic [ADDR_W-1:0]  w_addr2 [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata [NUM_REQ];
    rf_cmd_t            w_cmd;
    rf_rsp_t            w_rsp;

    logic               r_iss_valid;
    logic               r_rf_we;
    rf_cmd_t            r_iss_cmd;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data1;
    logic [DATA_W-1:0]  r_rsp_data2;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr1[g] = bus.req_addr1[g*ADDR_W +: ADDR_W];
        assign w_addr2[g] = bus.req_addr2[g*ADDR_W +: ADDR_W];
        assign w_wdata[g] = bus.req_wdata[g*DATA_W +: DATA_W];
    end

    // No grant can be seen while reset is held.
    assign w_req = reset ? '0 : bus.req_valid;

    rr_arbiter #(
        .NUM_REQ      (NUM_REQ)
    ) u_rr_arbiter (
        .clk          (clk),
        .reset        (reset),
        .i_req        (w_req),
`ifdef RF_ARB_LOCK_EN
        .i_lock       (bus.req_lock),
`endif
        .o_grant_c    (w_grant),
        .o_grant_id_c (w_grant_id)
    );

    assign bus.req_ready = w_grant;

    always_comb begin
        w_cmd       = '0;
        w_cmd.write = bus.req_write[w_grant_id];
        w_cmd.addr1 = RF_ADDR_W'(w_addr1[w_grant_id]);
        w_cmd.addr2 = RF_ADDR_W'(w_addr2[w_grant_id]);
        w_cmd.wdata = RF_DATA_W'(w_wdata[w_grant_id]);
        w_cmd.id    = RF_ID_W'(w_grant_id);
    end

    // Issue register: address/data hold through idle cycles, only valid clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_iss_valid <= 1'b0;
            r_rf_we     <= 1'b0;
            r_iss_cmd   <= '0;
        end else begin
            r_iss_valid <= |w_grant;
            r_rf_we     <= (|w_grant) & w_cmd.write;
            if (|w_grant) begin
                r_iss_cmd <= w_cmd;
            end
        end
    end

    assign rf_write_flag = r_rf_we;
    assign rf_addr1      = ADDR_W'(r_iss_cmd.addr1);
    assign rf_addr2      = ADDR_W'(r_iss_cmd.addr2);
    assign rf_data_in    = DATA_W'(r_iss_cmd.wdata);

    // Writes echo their data; reads take the register file's combinational output.
    always_comb begin
        w_rsp       = '0;
        w_rsp.id    = r_iss_cmd.id;
        w_rsp.data1 = r_iss_cmd.write ? r_iss_cmd.wdata : RF_DATA_W'(rf_data_out1);
        w_rsp.data2 = r_iss_cmd.write ? '0 : RF_DATA_W'(rf_data_out2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= '0;
            r_rsp_data1 <= '0;
            r_rsp_data2 <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (r_iss_valid) begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (w_rsp.id == RF_ID_W'(i)) begin
                        r_rsp_valid[i] <= 1'b1;
                    end
                end
                r_rsp_data1 <= DATA_W'(w_rsp.data1);
                r_rsp_data2 <= DATA_W'(w_rsp.data2);
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data1 = r_rsp_data1;
    assign bus.rsp_data2 = r_rsp_data2;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a 4 x 512-bit register file model.
// Define RF_ARB_LOCK_EN to include the lock scenario.
module tb_rf_port_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned DW = 512;
    localparam int unsigned AW = 2;
    localparam logic [DW-1:0] PAT_5A   = {64{8'h5A}};
    localparam logic [DW-1:0] PAT_1234 = DW'(16'h1234);
    localparam logic [DW-1:0] PAT_FF   = DW'(8'hFF);
    localparam logic [DW-1:0] ZERO     = '0;

    logic          clk = 1'b0;
    logic          reset;
    logic          rf_write_flag;
    logic [AW-1:0] rf_addr1;
    logic [AW-1:0] rf_addr2;
    logic [DW-1:0] rf_data_in;
    logic [DW-1:0] rf_data_out1;
    logic [DW-1:0] rf_data_out2;
    logic [DW-1:0] rf_mem [4];
    logic [NR-1:0] rr_exp [3];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    rf_port_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

    rf_port_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .rf_write_flag(rf_write_flag),
        .rf_addr1     (rf_addr1),
        .rf_addr2     (rf_addr2),
        .rf_data_in   (rf_data_in),
        .rf_data_out1 (rf_data_out1),
        .rf_data_out2 (rf_data_out2)
    );

    always #5 clk = ~clk;

    // Register file model: combinational read, write at clock edge.
    assign rf_data_out1 = rf_mem[rf_addr1];
    assign rf_data_out2 = rf_mem[rf_addr2];
    always @(posedge clk) begin
        if (rf_write_flag) rf_mem[rf_addr1] <= rf_data_in;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr1 = '0;
        bus.req_addr2 = '0;
        bus.req_wdata = '0;
`ifdef RF_ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
    endtask

    task automatic drive(input int r, input logic w, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [DW-1:0] d);
        bus.req_valid[r]             = 1'b1;
        bus.req_write[r]             = w;
        bus.req_addr1[r*AW +: AW]    = a1;
        bus.req_addr2[r*AW +: AW]    = a2;
        bus.req_wdata[r*DW +: DW]    = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_reqs();
        bus.req_valid = '1;
        tick();
        tick();
        chk_cnt++; if (bus.req_ready !== 3'b000) $display("FAIL reset_ready: got %b exp 000", bus.req_ready); else pass_cnt++;
        chk_cnt++; if (bus.rsp_valid !== 3'b000) $display("FAIL reset_rsp_valid: got %b exp 000", bus.rsp_valid); else pass_cnt++;
        chk_cnt++; if (bus.rsp_data1 !== ZERO) $display("FAIL reset_rsp_data1: got %0h exp 0", bus.rsp_data1); else pass_cnt++;
        chk_cnt++; if (bus.rsp_data2 !== ZERO) $display("FAIL reset_rsp_data2: got %0h exp 0", bus.rsp_data2); else pass_cnt++;
        chk_cnt++; if (rf_write_flag !== 1'b0) $display("FAIL reset_wflag: got %b exp 0", rf_write_flag); else pass_cnt++;
        chk_cnt++; if ({rf_addr1, rf_addr2} !== 4'h0) $display("FAIL reset_addr: got %h exp 0", {rf_addr1, rf_addr2}); else pass_cnt++;
        chk_cnt++; if (rf_data_in !== ZERO) $display("FAIL reset_data_in: got %0h exp 0", rf_data_in); else pass_cnt++;
        clear_reqs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        clear_reqs();
        drive(0, 1'b1, 2'd1, 2'd0, PAT_5A);
        #1;
        chk_cnt++; if (bus.req_ready !== 3'b001) $display("FAIL wr_ready: got %b exp 001", bus.req_ready); else pass_cnt++;
        tick();
        clear_reqs();
        drive(0, 1'b0, 2'd1, 2'd1, ZERO);
        #1;
        chk_cnt++; if (bus.req_ready !== 3'b001) $display("FAIL rd_ready: got %b exp 001", bus.req_ready); else pass_cnt++;
        chk_cnt++; if (rf_write_flag !== 1'b1) $display("FAIL wr_flag: got %b exp 1", rf_write_flag); else pass_cnt++;
        chk_cnt++; if (rf_addr1 !== 2'd1) $display("FAIL wr_addr: got %0d exp 1", rf_addr1); else pass_cnt++;
        chk_cnt++; if (rf_data_in !== PAT_5A) $display("FAIL wr_data_in: got %0h exp %0h", rf_data_in, PAT_5A); else pass_cnt++;
        tick();
        clear_reqs();
        #1;
        chk_cnt++; if (rf_write_flag !== 1'b0) $display("FAIL wr_flag_one_cycle: got %b exp 0", rf_write_flag); else pass_cnt++;
        chk_cnt++; if (bus.rsp_valid !== 3'b001) $display("FAIL wr_rsp_valid: got %b exp 001", bus.rsp_valid); else pass_cnt++;
        chk_cnt++; if (bus.rsp_data1 !== PAT_5A) $display("FAIL wr_rsp_data1: got %0h exp %0h", bus.rsp_data1, PAT_5A); else pass_cnt++;
        chk_cnt++; if (bus.rsp_data2 !== ZERO) $display("FAIL wr_rsp_data2: got %0h exp 0", bus.rsp_data2); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.rsp_valid !== 3'b001) $display("FAIL rd_rsp_valid: got %b exp 001", bus.rsp_valid); else pass_cnt++;
        chk_cnt++; if (bus.rsp_data1 !== PAT_5A) $display("FAIL rd_data1: got %0h exp %0h", bus.rsp_data1, PAT_5A); else pass_cnt++;
        chk_cnt++; if (bus.rsp_data2 !== PAT_5A) $display("FAIL rd_data2: got %0h exp %0h", bus.rsp_data2, PAT_5A); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.rsp_valid !== 3'b000) $display("FAIL rsp_pulse: got %b exp 000", bus.rsp_valid); else pass_cnt++;
        chk_cnt++; if (bus.rsp_data1 !== PAT_5A) $display("FAIL rsp_hold: got %0h exp %0h", bus.rsp_data1, PAT_5A); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        reset = 1'b1;
        clear_reqs();
        tick();
        reset = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            clear_reqs();
            if (k < 6) begin
                for (int r = 0; r < 3; r++) drive(r, 1'b0, 2'd1, 2'd1, ZERO);
            end
            #1;
            if (k < 6) begin
                chk_cnt++; if (bus.req_ready !== rr_exp[k % 3]) $display("FAIL rr_ready[%0d]: got %b exp %b", k, bus.req_ready, rr_exp[k % 3]); else pass_cnt++;
            end
            if (k >= 2) begin
                chk_cnt++; if (bus.rsp_valid !== rr_exp[(k - 2) % 3]) $display("FAIL rr_rsp[%0d]: got %b exp %b", k, bus.rsp_valid, rr_exp[(k - 2) % 3]); else pass_cnt++;
                chk_cnt++; if (bus.rsp_data1 !== PAT_5A) $display("FAIL rr_data1[%0d]: got %0h exp %0h", k, bus.rsp_data1, PAT_5A); else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_raw();
        clear_reqs();
        drive(1, 1'b1, 2'd3, 2'd0, PAT_1234);
        #1;
        chk_cnt++; if (bus.req_ready !== 3'b010) $display("FAIL raw_wr_ready: got %b exp 010", bus.req_ready); else pass_cnt++;
        tick();
        clear_reqs();
        drive(2, 1'b0, 2'd3, 2'd0, ZERO);
        #1;
        chk_cnt++; if (bus.req_ready !== 3'b100) $display("FAIL raw_rd_ready: got %b exp 100", bus.req_ready); else pass_cnt++;
        tick();
        clear_reqs();
        #1;
        chk_cnt++; if (bus.rsp_valid !== 3'b010) $display("FAIL raw_wr_rsp: got %b exp 010", bus.rsp_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.rsp_valid !== 3'b100) $display("FAIL raw_rd_rsp: got %b exp 100", bus.rsp_valid); else pass_cnt++;
        chk_cnt++; if (bus.rsp_data1 !== PAT_1234) $display("FAIL raw_data1: got %0h exp %0h", bus.rsp_data1, PAT_1234); else pass_cnt++;
        chk_cnt++; if (bus.rsp_data2 !== ZERO) $display("FAIL raw_data2: got %0h exp 0", bus.rsp_data2); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        clear_reqs();
        drive(0, 1'b1, 2'd2, 2'd0, PAT_FF);
        #1;
        chk_cnt++; if (bus.req_ready !== 3'b001) $display("FAIL mid_wr_ready: got %b exp 001", bus.req_ready); else pass_cnt++;
        tick();
        clear_reqs();
        #1;
        chk_cnt++; if (rf_write_flag !== 1'b1) $display("FAIL mid_flag_pre: got %b exp 1", rf_write_flag); else pass_cnt++;
        reset = 1'b1;
        #1;
        chk_cnt++; if (rf_write_flag !== 1'b0) $display("FAIL mid_flag_async: got %b exp 0", rf_write_flag); else pass_cnt++;
        chk_cnt++; if (bus.rsp_valid !== 3'b000) $display("FAIL mid_no_rsp0: got %b exp 000", bus.rsp_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.rsp_valid !== 3'b000) $display("FAIL mid_no_rsp1: got %b exp 000", bus.rsp_valid); else pass_cnt++;
        reset = 1'b0;
        tick();
        chk_cnt++; if (bus.rsp_valid !== 3'b000) $display("FAIL mid_no_rsp2: got %b exp 000", bus.rsp_valid); else pass_cnt++;
        drive(0, 1'b0, 2'd2, 2'd2, ZERO);
        drive(1, 1'b0, 2'd2, 2'd2, ZERO);
        #1;
        chk_cnt++; if (bus.req_ready !== 3'b001) $display("FAIL mid_ptr_reset: got %b exp 001", bus.req_ready); else pass_cnt++;
        tick();
        clear_reqs();
        tick();
        chk_cnt++; if (bus.rsp_valid !== 3'b001) $display("FAIL a3_rsp: got %b exp 001", bus.rsp_valid); else pass_cnt++;
        chk_cnt++; if (bus.rsp_data1 !== ZERO) $display("FAIL a3_data1: got %0h exp 0", bus.rsp_data1); else pass_cnt++;
        chk_cnt++; if (bus.rsp_data2 !== ZERO) $display("FAIL a3_data2: got %0h exp 0", bus.rsp_data2); else pass_cnt++;
        tick();
    endtask

    task automatic test_pointer_hold();
        clear_reqs();
        tick();
        tick();
        drive(0, 1'b0, 2'd3, 2'd0, ZERO);
        drive(2, 1'b0, 2'd3, 2'd0, ZERO);
        #1;
        chk_cnt++; if (bus.req_ready !== 3'b100) $display("FAIL hold_ptr_a: got %b exp 100", bus.req_ready); else pass_cnt++;
        tick();
        #1;
        chk_cnt++; if (bus.req_ready !== 3'b001) $display("FAIL hold_wrap_b: got %b exp 001", bus.req_ready); else pass_cnt++;
        tick();
        clear_reqs();
        tick();
        chk_cnt++; if (rf_write_flag !== 1'b0) $display("FAIL idle_flag: got %b exp 0", rf_write_flag); else pass_cnt++;
        chk_cnt++; if (rf_addr1 !== 2'd3) $display("FAIL idle_addr_hold: got %0d exp 3", rf_addr1); else pass_cnt++;
        chk_cnt++; if (bus.rsp_valid !== 3'b001) $display("FAIL hold_rsp: got %b exp 001", bus.rsp_valid); else pass_cnt++;
        chk_cnt++; if (bus.rsp_data1 !== PAT_1234) $display("FAIL hold_rsp_data1: got %0h exp %0h", bus.rsp_data1, PAT_1234); else pass_cnt++;
        tick();
    endtask

`ifdef RF_ARB_LOCK_EN
    task automatic test_lock();
        logic [NR-1:0] exp_g [4];
        exp_g[0] = 3'b100; exp_g[1] = 3'b100; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        reset = 1'b1;
        clear_reqs();
        tick();
        reset = 1'b0;
        drive(1, 1'b0, 2'd0, 2'd0, ZERO);
        #1;
        chk_cnt++; if (bus.req_ready !== 3'b010) $display("FAIL lock_setup: got %b exp 010", bus.req_ready); else pass_cnt++;
        tick();
        for (int c = 0; c < 4; c++) begin
            clear_reqs();
            for (int r = 0; r < 3; r++) drive(r, 1'b0, 2'd0, 2'd0, ZERO);
            bus.req_lock[2] = (c < 2);
            #1;
            chk_cnt++; if (bus.req_ready !== exp_g[c]) $display("FAIL lock_grant[%0d]: got %b exp %b", c, bus.req_ready, exp_g[c]); else pass_cnt++;
            tick();
        end
        clear_reqs();
        tick();
        tick();
    endtask
`endif

    initial begin
        reset = 1'b1;
        clear_reqs();
        rr_exp[0] = 3'b001;
        rr_exp[1] = 3'b010;
        rr_exp[2] = 3'b100;
        for (int i = 0; i < 4; i++) rf_mem[i] <= '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_raw();
        test_reset_mid();
        test_pointer_hold();
`ifdef RF_ARB_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
